// File: rtl/hash_table_axis.sv
// hash_table_axis: d-left style bucketed hash table behind a ready/valid stream.
// Each beat carries {op, key, data}. Lookup, insert and delete run against
// every table in parallel, and each non-nop beat returns one response beat.
// Slot storage is kept flat so that every write hits a single computed index.
module hash_table_axis #(
  parameter int KEY_WIDTH           = 32,
  parameter int DATA_WIDTH          = 30,
  parameter int NUMBER_OF_TABLES    = 8,
  parameter int HASH_TABLE_MAX_SIZE = 11,
  parameter int BUCKET_SIZE         = 2,
  parameter int KEEP_WIDTH          = 1
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [2+KEY_WIDTH+DATA_WIDTH-1:0]                    data_i,
  input  logic                                                 valid_i,
  input  logic                                                 ready_i,
  input  logic [KEEP_WIDTH-1:0]                                keep_i,
  input  logic                                                 last_i,
  input  logic [NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE*KEY_WIDTH-1:0] matrixes_i,
  output logic                                                 ready_o,
  output logic                                                 valid_o,
  output logic [KEEP_WIDTH-1:0]                                keep_o,
  output logic                                                 last_o,
  output logic [2+KEY_WIDTH+DATA_WIDTH-1:0]                    data_o
);

  localparam int BeatWidth = 2 + KEY_WIDTH + DATA_WIDTH;
  localparam int Depth     = 1 << HASH_TABLE_MAX_SIZE;
  localparam int SlotCount = NUMBER_OF_TABLES * Depth * BUCKET_SIZE;
  localparam int FlatW     = (SlotCount > 1) ? $clog2(SlotCount) : 1;

  localparam logic [1:0] OpNop    = 2'b00;
  localparam logic [1:0] OpLookup = 2'b01;
  localparam logic [1:0] OpInsert = 2'b10;
  localparam logic [1:0] OpDelete = 2'b11;

  // Slot storage, flat index = (table*Depth + bucket)*BUCKET_SIZE + slot
  logic [SlotCount-1:0]  slotValid_q;
  logic [KEY_WIDTH-1:0]  slotKey_q  [SlotCount];
  logic [DATA_WIDTH-1:0] slotData_q [SlotCount];

  // Request fields
  logic [1:0]            reqOp;
  logic [KEY_WIDTH-1:0]  reqKey;
  logic [DATA_WIDTH-1:0] reqData;

  assign reqOp   = data_i[BeatWidth-1 -: 2];
  assign reqKey  = data_i[DATA_WIDTH +: KEY_WIDTH];
  assign reqData = data_i[DATA_WIDTH-1:0];

  // Per-table bucket index
  logic [HASH_TABLE_MAX_SIZE-1:0] bucketIdx [NUMBER_OF_TABLES];

  // Search results
  logic                  hitFound;
  logic [FlatW-1:0]      hitFlat;
  logic [DATA_WIDTH-1:0] hitData;
  logic                  freeFound;
  logic [FlatW-1:0]      freeFlat;

  // Handshake and write strobes
  logic accept;
  logic insertHit;
  logic insertNew;
  logic deleteHit;

  // Response register
  logic                  respValid_q, respValid_d;
  logic [BeatWidth-1:0]  respData_q,  respData_d;
  logic [KEEP_WIDTH-1:0] respKeep_q,  respKeep_d;
  logic                  respLast_q,  respLast_d;
  logic [BeatWidth-1:0]  respBeat;

  // H3 hash: each index bit is the parity of the key masked by one matrix row
  always_comb begin
    for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
      bucketIdx[t] = '0;
      for (int j = 0; j < HASH_TABLE_MAX_SIZE; j++) begin
        bucketIdx[t][j] = ^(reqKey & matrixes_i[(t*HASH_TABLE_MAX_SIZE+j)*KEY_WIDTH +: KEY_WIDTH]);
      end
    end
  end

  // Scan every slot of the addressed buckets; the first hit and the first free
  // slot in (table, slot) order win, which gives the lowest-table placement
  always_comb begin
    logic [FlatW-1:0] slotFlat;
    slotFlat  = '0;
    hitFound  = 1'b0;
    hitFlat   = '0;
    hitData   = '0;
    freeFound = 1'b0;
    freeFlat  = '0;
    for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
      for (int s = 0; s < BUCKET_SIZE; s++) begin
        slotFlat = FlatW'((t*Depth + int'(bucketIdx[t]))*BUCKET_SIZE + s);
        if (slotValid_q[slotFlat] && (slotKey_q[slotFlat] == reqKey)) begin
          if (!hitFound) begin
            hitFound = 1'b1;
            hitFlat  = slotFlat;
            hitData  = slotData_q[slotFlat];
          end
        end else if (!slotValid_q[slotFlat] && !freeFound) begin
          freeFound = 1'b1;
          freeFlat  = slotFlat;
        end
      end
    end
  end

  assign ready_o   = reset && (ready_i || !respValid_q);
  assign accept    = valid_i && ready_o;
  assign insertHit = accept && (reqOp == OpInsert) && hitFound;
  assign insertNew = accept && (reqOp == OpInsert) && !hitFound && freeFound;
  assign deleteHit = accept && (reqOp == OpDelete) && hitFound;

  // Form the response beat for the current request
  always_comb begin
    respBeat = '0;
    case (reqOp)
      OpLookup: respBeat = hitFound ? {OpLookup, reqKey, hitData}
                                    : {OpNop, reqKey, {DATA_WIDTH{1'b0}}};
      OpInsert: respBeat = (hitFound || freeFound) ? {OpInsert, reqKey, reqData}
                                                   : {OpNop, reqKey, reqData};
      OpDelete: respBeat = hitFound ? {OpDelete, reqKey, reqData}
                                    : {OpNop, reqKey, reqData};
      default:  respBeat = '0;
    endcase
  end

  // Valid bits: set on a fresh insert, cleared on a delete hit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slotValid_q <= '0;
    end else if (insertNew) begin
      slotValid_q[freeFlat] <= 1'b1;
    end else if (deleteHit) begin
      slotValid_q[hitFlat] <= 1'b0;
    end
  end

  // Key/data payload; meaningless until the matching valid bit is set
  always_ff @(posedge clk) begin
    if (insertNew) begin
      slotKey_q[freeFlat]  <= reqKey;
      slotData_q[freeFlat] <= reqData;
    end else if (insertHit) begin
      slotData_q[hitFlat] <= reqData;
    end
  end

  // Next response: load on accept (nops drop valid), drain when downstream takes it
  always_comb begin
    respValid_d = respValid_q;
    respData_d  = respData_q;
    respKeep_d  = respKeep_q;
    respLast_d  = respLast_q;
    if (accept) begin
      respValid_d = (reqOp != OpNop);
      respKeep_d  = keep_i;
      respLast_d  = last_i;
      if (reqOp != OpNop) begin
        respData_d = respBeat;
      end
    end else if (ready_i) begin
      respValid_d = 1'b0;
    end
  end

  // Response register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      respValid_q <= 1'b0;
      respData_q  <= '0;
      respKeep_q  <= '0;
      respLast_q  <= 1'b0;
    end else begin
      respValid_q <= respValid_d;
      respData_q  <= respData_d;
      respKeep_q  <= respKeep_d;
      respLast_q  <= respLast_d;
    end
  end

  assign valid_o = respValid_q;
  assign data_o  = respData_q;
  assign keep_o  = respKeep_q;
  assign last_o  = respLast_q;

endmodule

// File: tb/tb_hash_table_axis.sv
// tb_hash_table_axis: directed vectors with hand-computed responses for hash_table_axis.
module tb_hash_table_axis;

  localparam int KeyW   = 32;
  localparam int DataW  = 30;
  localparam int Tables = 8;
  localparam int HashW  = 11;
  localparam int BeatW  = 2 + KeyW + DataW;
  localparam int MatW   = Tables * HashW * KeyW;

  logic             clk;
  logic             reset;
  logic [BeatW-1:0] dataIn;
  logic             validIn;
  logic             readyIn;
  logic [0:0]       keepIn;
  logic             lastIn;
  logic [MatW-1:0]  matrixes;
  logic             readyOut;
  logic             validOut;
  logic [0:0]       keepOut;
  logic             lastOut;
  logic [BeatW-1:0] dataOut;

  int checkCount;
  int passCount;

  // Expected response for the most recently driven beat
  logic             pendArmed;
  logic             pendValid;
  logic [BeatW-1:0] pendBeat;
  logic             pendKeep;
  logic             pendLast;
  string            pendTag;

  hash_table_axis dut (
    .clk        (clk),
    .reset      (reset),
    .data_i     (dataIn),
    .valid_i    (validIn),
    .ready_i    (readyIn),
    .keep_i     (keepIn),
    .last_i     (lastIn),
    .matrixes_i (matrixes),
    .ready_o    (readyOut),
    .valid_o    (validOut),
    .keep_o     (keepOut),
    .last_o     (lastOut),
    .data_o     (dataOut)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [BeatW-1:0] mkBeat(input logic [1:0] op, input logic [31:0] key,
                                              input logic [29:0] data);
    return {op, key, data};
  endfunction

  task automatic checkOutput(input string tag, input logic [BeatW-1:0] observed,
                             input logic [BeatW-1:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkPending();
    if (pendArmed) begin
      checkOutput({pendTag, ".valid"}, BeatW'(validOut), BeatW'(pendValid));
      if (pendValid) begin
        checkOutput({pendTag, ".data"}, dataOut, pendBeat);
        checkOutput({pendTag, ".keep"}, BeatW'(keepOut), BeatW'(pendKeep));
        checkOutput({pendTag, ".last"}, BeatW'(lastOut), BeatW'(pendLast));
      end
    end
  endtask

  // Check the previous response, then drive one beat for the next edge
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] key,
                               input logic [29:0] data, input logic [1:0] expResp,
                               input logic [29:0] expData, input string tag);
    @(negedge clk);
    checkPending();
    validIn   = 1'b1;
    readyIn   = 1'b1;
    dataIn    = mkBeat(op, key, data);
    keepIn    = key[0];
    lastIn    = key[1];
    pendArmed = 1'b1;
    pendValid = (op != 2'b00);
    pendBeat  = mkBeat(expResp, key, expData);
    pendKeep  = key[0];
    pendLast  = key[1];
    pendTag   = tag;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    checkPending();
    validIn   = 1'b0;
    pendArmed = 1'b1;
    pendValid = 1'b0;
    pendTag   = "idle";
  endtask

  initial begin
    clk        = 1'b0;
    checkCount = 0;
    passCount  = 0;
    pendArmed  = 1'b0;
    pendValid  = 1'b0;
    pendBeat   = '0;
    pendKeep   = 1'b0;
    pendLast   = 1'b0;
    pendTag    = "";
    for (int t = 0; t < Tables; t++) begin
      for (int j = 0; j < HashW; j++) begin
        matrixes[(t*HashW+j)*KeyW +: KeyW] = (32'h0101_0101 * (t + 1)) ^ (32'h1 << ((j*3 + t) % 32));
      end
    end

    // Reset asserted with an insert of key 1 presented: it must be ignored
    reset   = 1'b0;
    validIn = 1'b1;
    readyIn = 1'b1;
    dataIn  = mkBeat(2'b10, 32'd1, 30'd1);
    keepIn  = 1'b1;
    lastIn  = 1'b1;
    #1;
    checkOutput("rst.ready", BeatW'(readyOut), '0);
    repeat (3) @(negedge clk);
    checkOutput("rst.valid", BeatW'(validOut), '0);
    checkOutput("rst.data", dataOut, '0);
    checkOutput("rst.keep", BeatW'(keepOut), '0);
    checkOutput("rst.last", BeatW'(lastOut), '0);
    reset   = 1'b1;
    validIn = 1'b0;

    applyStimulus(2'b01, 32'd1, 30'd0, 2'b00, 30'd0, "lkup1.miss");
    applyStimulus(2'b10, 32'd1, 30'd1, 2'b10, 30'd1, "ins1");
    applyStimulus(2'b01, 32'd1, 30'd0, 2'b01, 30'd1, "lkup1.hit");

    for (int k = 2; k <= 7; k++) begin
      applyStimulus(2'b10, 32'(k), 30'(k), 2'b10, 30'(k), $sformatf("ins%0d", k));
    end
    for (int k = 2; k <= 7; k++) begin
      applyStimulus(2'b01, 32'(k), 30'd0, 2'b01, 30'(k), $sformatf("lkup%0d", k));
    end

    applyStimulus(2'b10, 32'd8, 30'd8, 2'b10, 30'd8, "ins8");
    applyStimulus(2'b11, 32'd8, 30'd0, 2'b11, 30'd0, "del8");
    applyStimulus(2'b01, 32'd8, 30'd0, 2'b00, 30'd0, "lkup8.miss");

    for (int k = 2; k <= 7; k++) begin
      applyStimulus(2'b11, 32'(k), 30'd0, 2'b11, 30'd0, $sformatf("del%0d", k));
    end
    for (int k = 2; k <= 7; k++) begin
      applyStimulus(2'b01, 32'(k), 30'd0, 2'b00, 30'd0, $sformatf("lkupdel%0d", k));
    end
    applyStimulus(2'b11, 32'd2, 30'd0, 2'b00, 30'd0, "del2.again");

    // Reset while the last response is still held must discard it
    @(negedge clk);
    checkPending();
    pendArmed = 1'b0;
    validIn   = 1'b0;
    reset     = 1'b0;
    #1;
    checkOutput("midrst.valid", BeatW'(validOut), '0);
    checkOutput("midrst.data", dataOut, '0);
    matrixes = '0;
    @(negedge clk);
    reset = 1'b1;

    // All keys collide in bucket 0: 8 tables x 2 slots hold exactly 16 keys
    for (int k = 100; k < 116; k++) begin
      applyStimulus(2'b10, 32'(k), 30'(k), 2'b10, 30'(k), $sformatf("fill%0d", k));
    end
    applyStimulus(2'b10, 32'd116, 30'd116, 2'b00, 30'd116, "ins116.full");
    applyStimulus(2'b10, 32'd100, 30'h55, 2'b10, 30'h55, "reins100");
    applyStimulus(2'b01, 32'd100, 30'd0, 2'b01, 30'h55, "lkup100");
    applyStimulus(2'b01, 32'd116, 30'd0, 2'b00, 30'd0, "lkup116.miss");
    applyStimulus(2'b00, 32'd115, 30'd0, 2'b00, 30'd0, "nop");
    applyStimulus(2'b01, 32'd115, 30'd0, 2'b01, 30'd115, "lkup115");
    applyStimulus(2'b11, 32'd101, 30'd0, 2'b11, 30'd0, "del101");

    // Stall: downstream not ready for 3 cycles while a lookup of 101 waits
    @(negedge clk);
    checkPending();
    readyIn   = 1'b0;
    validIn   = 1'b1;
    dataIn    = mkBeat(2'b01, 32'd101, 30'd0);
    keepIn    = 1'b1;
    lastIn    = 1'b0;
    pendArmed = 1'b1;
    pendValid = 1'b1;
    pendBeat  = mkBeat(2'b00, 32'd101, 30'd0);
    pendKeep  = 1'b1;
    pendLast  = 1'b0;
    pendTag   = "lkup101.afterstall";
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d.ready", c), BeatW'(readyOut), '0);
      checkOutput($sformatf("stall%0d.valid", c), BeatW'(validOut), BeatW'(1'b1));
      checkOutput($sformatf("stall%0d.data", c), dataOut, mkBeat(2'b11, 32'd101, 30'd0));
    end
    readyIn = 1'b1;
    applyStimulus(2'b10, 32'd101, 30'h22, 2'b10, 30'h22, "ins101");
    applyStimulus(2'b01, 32'd101, 30'd0, 2'b01, 30'h22, "lkup101");
    idleCycle();
    @(negedge clk);
    checkPending();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/hash_table_axis.md
# hash_table_axis

Multi-table hash table (d-left style, bucketed) with an AXI-Stream-like request/response interface. Each input beat carries an opcode, key and data; the block performs insert, lookup or delete across NUMBER_OF_TABLES hash tables in parallel and returns one response beat per operation. Hash indices come from per-table XOR (H3) matrices that a constant matrix source elsewhere in the design supplies as a flat vector.

## Interface
Parameters:
- KEY_WIDTH, 32, key bits.
- DATA_WIDTH, 30, value bits.
- NUMBER_OF_TABLES, 8, independent hash tables searched in parallel.
- HASH_TABLE_MAX_SIZE, 11, index width per table (depth 2^11 buckets).
- BUCKET_SIZE, 2, slots per bucket.
- KEEP_WIDTH, 1, width of the keep sideband.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all slot-valid bits and output state.
- data_i  in  2+KEY_WIDTH+DATA_WIDTH  {op[1:0], key, data}; op 00 nop, 01 lookup, 10 insert, 11 delete.
- valid_i  in  1  input beat valid.
- ready_i  in  1  downstream ready.
- keep_i  in  KEEP_WIDTH  sideband, forwarded.
- last_i  in  1  sideband, forwarded.
- matrixes_i  in  NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE*KEY_WIDTH  hash matrices; row j of table t at bits [(t*HASH_TABLE_MAX_SIZE+j)*KEY_WIDTH +: KEY_WIDTH].
- ready_o  out  1  block can accept a beat.
- valid_o  out  1  response valid.
- keep_o  out  KEEP_WIDTH  forwarded keep.
- last_o  out  1  forwarded last.
- data_o  out  2+KEY_WIDTH+DATA_WIDTH  {resp[1:0], key, data}.

## Operation
- Hash: index_t bit j = XOR-reduce(key AND row j of table t).
- Storage: per table, 2^HASH_TABLE_MAX_SIZE buckets of BUCKET_SIZE slots {valid, key, data}. Reads are combinational (register arrays); writes happen at the clock edge of acceptance.
- Lookup (01): search all slots of bucket index_t in every table. On a hit, resp=01 and data = stored value. On a miss, resp=00 and data=0.
- Insert (10):
  - If the key is already present, overwrite its data in place; resp=10.
  - Otherwise write into the lowest-numbered table with a free slot in its bucket, using the lowest free slot; resp=10.
  - If no free slot exists anywhere, the table is unchanged and resp=00.
- Delete (11): clear the valid bit of the matching slot; resp=11. If the key is absent, resp=00 and the table is unchanged.
- Nop (00): accepted, no table change, no response beat.
- A key never occupies more than one slot.
- data_o key field echoes the request key. For insert and delete responses, the data field echoes the request data.
- keep_o and last_o carry the values accepted with the beat.

## Timing
- Accept when valid_i && ready_o. ready_o = ready_i || !valid_o; forced 0 while reset is asserted.
- Latency is 1 cycle: the response is registered on the acceptance edge; valid_o rises the next cycle.
- Throughput is one operation per cycle. Back-to-back operations on the same key see the prior result, with no hazard bubble (e.g. an insert followed by a lookup in the next cycle hits).
- Stall: while valid_o && !ready_i, the response register holds and no beat is accepted.
- Reset values: valid_o=0, data_o=0, keep_o=0, last_o=0, all slots invalid. Beats presented during reset are ignored. Reset asserted mid-operation discards the in-flight response.
- matrixes_i is treated as static; changing it invalidates stored placements, and behaviour in that case is undefined.

## Test plan
- Insert key 1/data 1 while reset is asserted; release reset; lookup key 1 -> resp=00 (miss). Then insert 1/1, then lookup 1 on the next cycle -> resp=01, data=1.
- Insert keys 2..7 with data equal to the key, back-to-back, then lookup 2..7 -> each resp=01 with data = key, one response per cycle, valid_o continuous.
- Insert key 8/data 8, delete 8, lookup 8 on consecutive cycles -> responses 10, 11, then 00 with data 0.
- Delete keys 2..7, then lookup 2..7 -> all resp=00. Delete key 2 again -> resp=00.
- With an all-zero matrix (every key maps to index 0), insert 16 distinct keys -> all resp=10. Insert a 17th key -> resp=00. Re-insert the 1st key with data 0x55 -> resp=10, and a lookup returns 0x55.
- Hold ready_i=0 for 3 cycles with valid_i=1 -> ready_o=0, data_o stable, no table change. Release ready_i -> operations resume in order with none lost.
